// File: rtl/mult_pkg.sv
// Shared constants for the HI/LO multiply sequencer: datapath widths,
// default watchdog limit and controller state encoding.
package mult_pkg;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned PLEN            = 64;
    localparam int unsigned TIMEOUT_DEFAULT = 300;
    localparam int unsigned CNT_W_DEFAULT   = 9;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StStart = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StFix   = 2'd3;

endpackage

// File: rtl/mult_sign_fix.sv
// Conditional two's-complement negation; used as |x| on the operands and as
// the final sign correction on the 64-bit product.
module mult_sign_fix #(
    parameter int unsigned W = 32
) (
    input  logic         neg_i,
    input  logic [W-1:0] val_i,
    output logic [W-1:0] val_o
);

    logic [W-1:0] one;

    assign one   = {{(W-1){1'b0}}, 1'b1};
    // |0x80..0| wraps back to 0x80..0, which is the correct unsigned magnitude.
    assign val_o = neg_i ? (~val_i + one) : val_i;

endmodule

// File: rtl/mult_hilo_ctrl.sv
// Sequencer around the shift-add multiplier: operand sign conversion, start/ready
// handshake with a watchdog, sign correction and the architectural HI/LO registers.
module mult_hilo_ctrl
    import mult_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W          = CNT_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mult_go,
    input  logic            mult_signed,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    input  logic            mthi_we,
    input  logic            mtlo_we,
    input  logic [XLEN-1:0] wr_data,
    output logic            mul_start,
    output logic [XLEN-1:0] mul_a,
    output logic [XLEN-1:0] mul_b,
    input  logic [PLEN-1:0] mul_product,
    input  logic            mul_ready,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam logic [CNT_W-1:0] WdLast = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]      state_q, state_d;
    logic            neg_q, neg_d;
    logic [XLEN-1:0] mul_a_q, mul_a_d;
    logic [XLEN-1:0] mul_b_q, mul_b_d;
    logic            mul_start_q, mul_start_d;
    logic [PLEN-1:0] p_q, p_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [CNT_W-1:0] wd_q, wd_d;

    logic [XLEN-1:0] mag_a, mag_b;
    logic [PLEN-1:0] result;

    mult_sign_fix #(.W(XLEN)) u_mag_a (
        .neg_i (mult_signed & rs_val[XLEN-1]),
        .val_i (rs_val),
        .val_o (mag_a)
    );

    mult_sign_fix #(.W(XLEN)) u_mag_b (
        .neg_i (mult_signed & rt_val[XLEN-1]),
        .val_i (rt_val),
        .val_o (mag_b)
    );

    mult_sign_fix #(.W(PLEN)) u_negate (
        .neg_i (neg_q),
        .val_i (p_q),
        .val_o (result)
    );

    always_comb begin
        state_d     = state_q;
        neg_d       = neg_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        mul_start_d = 1'b0;
        p_d         = p_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        done_d      = 1'b0;
        err_d       = err_q;
        wd_d        = wd_q;

        unique case (state_q)
            StIdle: begin
                // MT writes and a new multiply may coincide; the multiply
                // overwrites both halves later.
                if (mthi_we) hi_d = wr_data;
                if (mtlo_we) lo_d = wr_data;
                if (mult_go) begin
                    neg_d       = mult_signed & (rs_val[XLEN-1] ^ rt_val[XLEN-1]);
                    mul_a_d     = mag_a;
                    mul_b_d     = mag_b;
                    mul_start_d = 1'b1;
                    state_d     = StStart;
                end
            end
            StStart: begin
                wd_d    = '0;
                state_d = StWait;
            end
            StWait: begin
                if (mul_ready) begin
                    p_d     = mul_product;
                    state_d = StFix;
                end else if (wd_q == WdLast) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            StFix: begin
                hi_d    = result[PLEN-1:XLEN];
                lo_d    = result[XLEN-1:0];
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            neg_q       <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_start_q <= 1'b0;
            p_q         <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            wd_q        <= '0;
        end else begin
            state_q     <= state_d;
            neg_q       <= neg_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            mul_start_q <= mul_start_d;
            p_q         <= p_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            wd_q        <= wd_d;
        end
    end

    assign mul_start = mul_start_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: doc/mult_hilo_ctrl.md
Name: mult_hilo_ctrl

Overview:
Sequencing stage directly upstream and downstream of the 32x32 shift-add multiplier in the multi-cycle MIPS datapath. Takes MULT/MULTU requests from the main control FSM and does signed-to-magnitude conversion. Pulses the multiplier's start, waits for its ready and applies the sign correction. Writes the 64-bit result into the architectural HI/LO registers. Also handles MTHI/MTLO and gives the control FSM a busy/stall indication for MFHI/MFLO.

Parameters:
TIMEOUT_CYCLES, 300, max cycles spent in WAIT before aborting (must exceed multiplier latency of 257)
CNT_W, 9, width of the watchdog counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
mult_go  in  1  one-cycle request to start a multiply (honoured only in IDLE)
mult_signed  in  1  1 = MULT (signed), 0 = MULTU; sampled with mult_go
rs_val  in  32  operand A; sampled with mult_go
rt_val  in  32  operand B; sampled with mult_go
mthi_we  in  1  write wr_data to HI (honoured only in IDLE)
mtlo_we  in  1  write wr_data to LO (honoured only in IDLE)
wr_data  in  32  data for MTHI/MTLO
mul_start  out  1  start pulse to multiplier
mul_a  out  32  magnitude operand A to multiplier
mul_b  out  32  magnitude operand B to multiplier
mul_product  in  64  multiplier product
mul_ready  in  1  multiplier done flag
hi  out  32  architectural HI
lo  out  32  architectural LO
busy  out  1  operation in flight; control FSM stalls MFHI/MFLO/MULT/MT* while high
done  out  1  one-cycle pulse in the first cycle the new HI/LO are visible
err  out  1  sticky watchdog-timeout flag; cleared only by reset

Behaviour:
- Reset (async, rst_n=0): state=IDLE; hi=lo=0; mul_start=0; mul_a=mul_b=0; busy=0; done=0; err=0; watchdog counter=0.
- All outputs are registered. busy = (state != IDLE).
- IDLE, mult_go=1:
  - Latch neg = mult_signed & (rs_val[31] ^ rt_val[31]).
  - mul_a = signed ? |rs_val| : rs_val; mul_b likewise from rt_val.
  - |0x80000000| = 0x80000000 as unsigned.
  - Next state START.
- START: mul_start=1 for exactly this cycle. Next state WAIT; watchdog cleared.
- WAIT: mul_start=0.
  - mul_ready is never sampled in START; the multiplier deasserts ready at the edge ending START.
  - mul_ready=1: capture mul_product into p_reg, go to FIX.
  - Otherwise increment the watchdog. At TIMEOUT_CYCLES: set err, return to IDLE, leave hi/lo unchanged, no done.
- FIX: result = neg ? (~p_reg + 1) mod 2^64 : p_reg. At the edge: hi=result[63:32], lo=result[31:0], done=1 next cycle, state IDLE.
- Latency with go sampled in cycle 0:
  - START in cycle 1; multiplier ready seen in cycle 258; FIX in cycle 259.
  - In cycle 260: hi/lo updated, done=1, busy=0. busy is high in cycles 1..259.
- MTHI/MTLO in IDLE write at the next edge.
  - Same cycle as mult_go: the MT write applies, and the multiply later overwrites both.
  - When not IDLE: ignored, no side effect.
- mult_go while busy: ignored.
- Reset mid-operation: immediate IDLE, mul_start low. A stale mul_ready afterwards is ignored in IDLE. The multiplier is unreset; the controller must not rely on its ready before issuing start.

Decomposition:
- Shared package mult_pkg:
  - state encoding IDLE/START/WAIT/FIX (2-bit localparams)
  - XLEN=32, PLEN=64
  - default TIMEOUT_CYCLES
- Sub-module mult_sign_fix (combinational), two instances:
  - magnitude: conditional 32-bit absolute value on inputs
  - negate: conditional 64-bit two's-complement negation on result

Test Plan:
- MULTU rs=3, rt=5 -> after 260 cycles hi=0x00000000, lo=0x0000000F, done pulse of 1 cycle, busy high cycles 1..259.
- MULT rs=0xFFFFFFFD (-3), rt=5 -> mul_a=3, mul_b=5; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000.
- MTHI 0x1234 in IDLE -> hi=0x1234 next cycle; MTLO 0xAAAA and a second mult_go issued while busy -> both ignored, final hi/lo equal the first multiply's result.
- Multiplier stub holding mul_ready=0 -> err=1 after TIMEOUT_CYCLES in WAIT, busy drops, hi/lo unchanged, no done.
- rst_n pulsed low in WAIT, with the stub raising mul_ready 5 cycles later -> hi/lo=0, state IDLE, no done, no hi/lo write.
